// File: rtl/riscv_core_hazard_ctrl_pkg.sv
// riscv_core_hazard_pkg: FSM encoding and default widths shared by the hazard controller files.
package riscv_core_hazard_pkg;
  localparam int DEF_W_REG_ADDR = 5;
  localparam int DEF_MDU_MAX_CYC = 80;
  localparam int DEF_W_MDU_CNT = 7;
  localparam logic [DEF_W_REG_ADDR-1:0] REG_X0 = '0;
  typedef enum logic {S_RUN = 1'b0, S_MDU_BUSY = 1'b1} state_e;
endpackage

// File: rtl/riscv_core_hazard_ctrl_if.sv
// riscv_core_hazard_ctrl_if: pipeline-side hazard inputs and per-register hold/clear controls.
interface riscv_core_hazard_ctrl_if
  import riscv_core_hazard_pkg::*;
#(
  parameter int W_REG_ADDR = DEF_W_REG_ADDR
);
  logic [W_REG_ADDR-1:0] i_id_rs1_addr, i_id_rs2_addr, i_ex_rd_addr;
  logic i_id_rs1_used, i_id_rs2_used, i_ex_mem_read, i_ex_redirect;
  logic i_ex_mdu_start, i_mdu_done, i_imem_stall, i_dmem_stall;
  logic o_pc_en_n, o_ifid_en_n, o_idex_en_n, o_exmem_en_n, o_memwb_en_n;
  logic o_ifid_clr, o_idex_clr, o_exmem_clr, o_memwb_clr, o_mdu_timeout;
  logic [31:0] o_perf_stall_cnt, o_perf_flush_cnt;
  modport master (
    output i_id_rs1_addr, i_id_rs2_addr, i_ex_rd_addr, i_id_rs1_used, i_id_rs2_used,
           i_ex_mem_read, i_ex_redirect, i_ex_mdu_start, i_mdu_done, i_imem_stall, i_dmem_stall,
    input  o_pc_en_n, o_ifid_en_n, o_idex_en_n, o_exmem_en_n, o_memwb_en_n,
           o_ifid_clr, o_idex_clr, o_exmem_clr, o_memwb_clr, o_mdu_timeout,
           o_perf_stall_cnt, o_perf_flush_cnt
  );
  modport slave (
    input  i_id_rs1_addr, i_id_rs2_addr, i_ex_rd_addr, i_id_rs1_used, i_id_rs2_used,
           i_ex_mem_read, i_ex_redirect, i_ex_mdu_start, i_mdu_done, i_imem_stall, i_dmem_stall,
    output o_pc_en_n, o_ifid_en_n, o_idex_en_n, o_exmem_en_n, o_memwb_en_n,
           o_ifid_clr, o_idex_clr, o_exmem_clr, o_memwb_clr, o_mdu_timeout,
           o_perf_stall_cnt, o_perf_flush_cnt
  );
endinterface

// File: rtl/riscv_core_hazard_ctrl_mdu_fsm.sv
// riscv_core_hazard_mdu_fsm: tracks MUL/DIV occupancy; a watchdog aborts an op that never completes.
module riscv_core_hazard_mdu_fsm
  import riscv_core_hazard_pkg::*;
#(
  parameter int P_MDU_MAX_CYC = DEF_MDU_MAX_CYC,
  parameter int W_MDU_CNT = DEF_W_MDU_CNT
) (
  input  logic i_pipe_clk,
  input  logic i_pipe_rst_n,
  input  logic start_i,
  input  logic done_i,
  output logic busy_o,
  output logic release_o,
  output logic timeout_o
);
  localparam logic [W_MDU_CNT-1:0] CNT_LAST = W_MDU_CNT'(P_MDU_MAX_CYC - 1);
  state_e state_q, state_d;
  logic [W_MDU_CNT-1:0] cnt_q, cnt_d;
  logic to_q, to_d, wd;
  assign busy_o = state_q == S_MDU_BUSY;
  assign release_o = busy_o & done_i;
  assign timeout_o = to_q;
  // Watchdog fires on the last allowed busy cycle only when the result has not arrived.
  assign wd = busy_o & ~done_i & (cnt_q == CNT_LAST);
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    to_d = to_q | wd;
    state_d = busy_o ? ((release_o | wd) ? S_RUN : S_MDU_BUSY) : (start_i ? S_MDU_BUSY : S_RUN);
    cnt_d = (busy_o & ~release_o & ~wd) ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge i_pipe_clk or negedge i_pipe_rst_n)
    if (!i_pipe_rst_n) begin
      state_q <= S_RUN;
      cnt_q <= '0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
    end
endmodule

// File: rtl/riscv_core_hazard_ctrl.sv
// riscv_core_hazard_ctrl: pipeline stall/flush controller; RISCV_HAZARD_PERF_EN adds stall/flush counters.
module riscv_core_hazard_ctrl
  import riscv_core_hazard_pkg::*;
#(
  parameter int W_REG_ADDR = DEF_W_REG_ADDR,
  parameter int P_MDU_MAX_CYC = DEF_MDU_MAX_CYC,
  parameter int W_MDU_CNT = DEF_W_MDU_CNT
) (
  input logic i_pipe_clk,
  input logic i_pipe_rst_n,
  riscv_core_hazard_ctrl_if.slave hz
);
  logic busy, rel, start, lu;
  logic [4:0] en_n;
  logic [3:0] clr;
  assign start = ~busy & ~hz.i_dmem_stall & hz.i_ex_mdu_start;
  assign lu = hz.i_ex_mem_read & (hz.i_ex_rd_addr != W_REG_ADDR'(REG_X0)) &
              ((hz.i_id_rs1_used & (hz.i_id_rs1_addr == hz.i_ex_rd_addr)) |
               (hz.i_id_rs2_used & (hz.i_id_rs2_addr == hz.i_ex_rd_addr)));
  riscv_core_hazard_mdu_fsm #(.P_MDU_MAX_CYC(P_MDU_MAX_CYC), .W_MDU_CNT(W_MDU_CNT)) u_mdu (
    .i_pipe_clk(i_pipe_clk), .i_pipe_rst_n(i_pipe_rst_n), .start_i(start), .done_i(hz.i_mdu_done),
    .busy_o(busy), .release_o(rel), .timeout_o(hz.o_mdu_timeout)
  );
  // en_n = {pc, ifid, idex, exmem, memwb}; clr = {ifid, idex, exmem, memwb}
  always_comb begin
    en_n = '0;
    clr = '0;
    if (busy) begin
      en_n = {3'b111, hz.i_dmem_stall, 1'b0};
      clr = {2'b00, ~rel, hz.i_dmem_stall};
    end else if (hz.i_dmem_stall) begin
      en_n = 5'b11110;
      clr = 4'b0001;
    end else if (hz.i_ex_mdu_start) begin
      en_n = 5'b11100;
      clr = 4'b0010;
    end else if (hz.i_ex_redirect) begin
      clr = 4'b1100;
    end else if (lu) begin
      en_n = 5'b11000;
      clr = 4'b0100;
    end else if (hz.i_imem_stall) begin
      en_n = 5'b10000;
      clr = 4'b1000;
    end
  end
  assign {hz.o_pc_en_n, hz.o_ifid_en_n, hz.o_idex_en_n, hz.o_exmem_en_n, hz.o_memwb_en_n} = en_n;
  assign {hz.o_ifid_clr, hz.o_idex_clr, hz.o_exmem_clr, hz.o_memwb_clr} = clr;
`ifdef RISCV_HAZARD_PERF_EN
  logic [31:0] stall_q, flush_q;
  logic redir_ok;
  assign redir_ok = ~busy & ~hz.i_dmem_stall & ~hz.i_ex_mdu_start & hz.i_ex_redirect;
  always_ff @(posedge i_pipe_clk or negedge i_pipe_rst_n)
    if (!i_pipe_rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + 32'(en_n[4]);
      flush_q <= flush_q + 32'(redir_ok);
    end
  assign hz.o_perf_stall_cnt = stall_q;
  assign hz.o_perf_flush_cnt = flush_q;
`else
  assign hz.o_perf_stall_cnt = '0;
  assign hz.o_perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_riscv_core_hazard_ctrl.sv
// tb_riscv_core_hazard_ctrl: two controllers (80- and 8-cycle watchdog) driven by shared stimulus, checked by a queued scoreboard.
module tb_riscv_core_hazard_ctrl;
  typedef struct packed {
    logic rst_n;
    logic [4:0] rs1, rs2, rd;
    logic rs1u, rs2u, ld, redir, start, done, imem, dmem;
  } stim_t;
  typedef struct packed {
    logic [4:0] en_n;
    logic [3:0] clr;
    logic to;
    logic [31:0] st, fl;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  stim_t s = '0;
  exp_t act[2];
  exp_t q[2][$];
  int checks = 0, errors = 0;
  bit m_busy[2];
  bit m_to[2];
  int m_cyc[2];
  int unsigned m_st[2], m_fl[2];
  int maxc[2] = '{80, 8};
  riscv_core_hazard_ctrl_if hzi[2] ();
  for (genvar g = 0; g < 2; g++) begin : g_conn
    assign hzi[g].i_id_rs1_addr = s.rs1;
    assign hzi[g].i_id_rs2_addr = s.rs2;
    assign hzi[g].i_ex_rd_addr = s.rd;
    assign hzi[g].i_id_rs1_used = s.rs1u;
    assign hzi[g].i_id_rs2_used = s.rs2u;
    assign hzi[g].i_ex_mem_read = s.ld;
    assign hzi[g].i_ex_redirect = s.redir;
    assign hzi[g].i_ex_mdu_start = s.start;
    assign hzi[g].i_mdu_done = s.done;
    assign hzi[g].i_imem_stall = s.imem;
    assign hzi[g].i_dmem_stall = s.dmem;
    assign act[g] = {hzi[g].o_pc_en_n, hzi[g].o_ifid_en_n, hzi[g].o_idex_en_n, hzi[g].o_exmem_en_n,
                     hzi[g].o_memwb_en_n, hzi[g].o_ifid_clr, hzi[g].o_idex_clr, hzi[g].o_exmem_clr,
                     hzi[g].o_memwb_clr, hzi[g].o_mdu_timeout, hzi[g].o_perf_stall_cnt,
                     hzi[g].o_perf_flush_cnt};
  end
  riscv_core_hazard_ctrl #(.P_MDU_MAX_CYC(80)) dut_a (
    .i_pipe_clk(clk), .i_pipe_rst_n(s.rst_n), .hz(hzi[0])
  );
  riscv_core_hazard_ctrl #(.P_MDU_MAX_CYC(8)) dut_b (
    .i_pipe_clk(clk), .i_pipe_rst_n(s.rst_n), .hz(hzi[1])
  );
  // Reference: expected response for the current cycle, then advance to the next cycle's state.
  task automatic model(input int d);
    exp_t e;
    bit lu, honour;
    if (!s.rst_n) begin
      m_busy[d] = 0;
      m_cyc[d] = 0;
      m_to[d] = 0;
      m_st[d] = 0;
      m_fl[d] = 0;
    end
    e = '0;
    e.to = m_to[d];
`ifdef RISCV_HAZARD_PERF_EN
    e.st = m_st[d];
    e.fl = m_fl[d];
`endif
    lu = s.ld && s.rd != 0 && ((s.rs1u && s.rs1 == s.rd) || (s.rs2u && s.rs2 == s.rd));
    honour = 0;
    if (m_busy[d]) begin
      e.en_n = {3'b111, s.dmem, 1'b0};
      e.clr = {2'b00, !s.done, s.dmem};
    end else if (s.dmem) begin
      e.en_n = 5'b11110;
      e.clr = 4'b0001;
    end else if (s.start) begin
      e.en_n = 5'b11100;
      e.clr = 4'b0010;
    end else if (s.redir) begin
      e.clr = 4'b1100;
      honour = 1;
    end else if (lu) begin
      e.en_n = 5'b11000;
      e.clr = 4'b0100;
    end else if (s.imem) begin
      e.en_n = 5'b10000;
      e.clr = 4'b1000;
    end
    q[d].push_back(e);
    if (s.rst_n) begin
      m_st[d] += 32'(e.en_n[4]);
      m_fl[d] += 32'(honour);
      if (m_busy[d]) begin
        if (s.done) m_busy[d] = 0;
        else if (m_cyc[d] == maxc[d] - 1) begin
          m_busy[d] = 0;
          m_to[d] = 1;
        end else m_cyc[d]++;
      end else if (!s.dmem && s.start) begin
        m_busy[d] = 1;
        m_cyc[d] = 0;
      end
    end
  endtask
  task automatic tick(input stim_t v);
    @(negedge clk);
    s = v;
    for (int d = 0; d < 2; d++) model(d);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      for (int d = 0; d < 2; d++)
        while (q[d].size() > 0) begin
          e = q[d].pop_front();
          checks++;
          if ({act[d].en_n, act[d].clr} !== {e.en_n, e.clr}) begin
            errors++;
            $display("FAIL ctl dut%0d t=%0t: got en_n=%b clr=%b, want en_n=%b clr=%b",
                     d, $time, act[d].en_n, act[d].clr, e.en_n, e.clr);
          end
          checks++;
          if (act[d].to !== e.to) begin
            errors++;
            $display("FAIL timeout dut%0d t=%0t: got %b, want %b", d, $time, act[d].to, e.to);
          end
          checks++;
          if ({act[d].st, act[d].fl} !== {e.st, e.fl}) begin
            errors++;
            $display("FAIL perf dut%0d t=%0t: got stall=%0d flush=%0d, want stall=%0d flush=%0d",
                     d, $time, act[d].st, act[d].fl, e.st, e.fl);
          end
        end
    end
  end
  initial begin : stimulus
    stim_t idle, v;
    idle = '0;
    idle.rst_n = 1;
    v = '0;
    repeat (3) tick(v);
    repeat (2) tick(idle);
    v = idle; v.ld = 1; v.rd = 5; v.rs1 = 5; v.rs1u = 1;
    tick(v);
    tick(idle);
    v = idle; v.ld = 1; v.rd = 0; v.rs1 = 0; v.rs1u = 1;
    tick(v);
    v = idle; v.ld = 1; v.rd = 7; v.rs2 = 7; v.rs2u = 1;
    tick(v);
    v.rs2u = 0;
    tick(v);
    v = idle; v.ld = 1; v.rd = 5; v.rs1 = 5; v.rs1u = 1; v.redir = 1; v.imem = 1;
    tick(v);
    v = idle; v.imem = 1;
    tick(v);
    v = idle; v.start = 1;
    tick(v);
    repeat (32) tick(idle);
    v = idle; v.done = 1;
    tick(v);
    repeat (3) tick(idle);
    v = idle; v.dmem = 1; v.redir = 1;
    repeat (3) tick(v);
    v = idle; v.redir = 1;
    tick(v);
    tick(idle);
    v = idle; v.start = 1;
    tick(v);
    tick(idle);
    v = idle; v.dmem = 1;
    tick(v);
    v = idle; v.done = 1;
    tick(v);
    v = idle; v.start = 1;
    tick(v);
    repeat (9) tick(idle);
    v = '0;
    repeat (2) tick(v);
    repeat (3) tick(idle);
    repeat (3000) begin
      v.rst_n = $urandom_range(0, 199) != 0;
      v.rs1 = 5'($urandom_range(0, 3));
      v.rs2 = 5'($urandom_range(0, 3));
      v.rd = 5'($urandom_range(0, 3));
      v.rs1u = 1'($urandom);
      v.rs2u = 1'($urandom);
      v.ld = $urandom_range(0, 9) < 3;
      v.redir = $urandom_range(0, 9) < 2;
      v.start = $urandom_range(0, 19) == 0;
      v.done = $urandom_range(0, 19) == 0;
      v.imem = $urandom_range(0, 9) < 2;
      v.dmem = $urandom_range(0, 19) < 3;
      tick(v);
    end
    tick(idle);
    @(negedge clk);
    #4;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (q[d].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d: got %0d pending, want 0", d, q[d].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
